// File: rtl/aes_pkg.sv
// Shared AES constants and GF(2^8) helpers for the iterative inverse cipher.
// Byte n of every 128-bit block sits at bits [8n+7:8n]: row n % 4, column n / 4.
package aes_pkg;

  localparam int BYTE_W = 8;
  localparam int N_ROWS = 4;  // byte index n -> (row n % N_ROWS, column n / N_ROWS)
  localparam int N_COLS = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } aes_state_e;

  localparam logic [7:0] S_BOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_S_BOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Indexed directly by the 4-bit round counter; unused slots are zero.
  localparam logic [7:0] RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < BYTE_W; i++) begin
      if (b[i]) acc = acc ^ aa;
      else      acc = acc;
      aa = xtime(aa);
    end
    return acc;
  endfunction

  function automatic logic [7:0] get_byte(input logic [127:0] s, input int col, input int row);
    return s[BYTE_W*(N_ROWS*col + row) +: BYTE_W];
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < N_COLS; c++)
      for (int r = 0; r < N_ROWS; r++)
        o[BYTE_W*(N_ROWS*c + r) +: BYTE_W] = get_byte(s, (c + N_COLS - r) % N_COLS, r);
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int n = 0; n < N_ROWS*N_COLS; n++)
      o[BYTE_W*n +: BYTE_W] = INV_S_BOX[s[BYTE_W*n +: BYTE_W]];
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < N_COLS; c++)
      for (int r = 0; r < N_ROWS; r++)
        o[BYTE_W*(N_ROWS*c + r) +: BYTE_W] =
          gmul(get_byte(s, c, r), 8'h0e) ^
          gmul(get_byte(s, c, (r + 1) % N_ROWS), 8'h0b) ^
          gmul(get_byte(s, c, (r + 2) % N_ROWS), 8'h0d) ^
          gmul(get_byte(s, c, (r + 3) % N_ROWS), 8'h09);
    return o;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[7:0], w[31:8]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {S_BOX[w[31:24]], S_BOX[w[23:16]], S_BOX[w[15:8]], S_BOX[w[7:0]]};
  endfunction

  // Undo one forward key-expansion step: recover round key r-1 from round key r.
  function automatic logic [127:0] inv_key_step(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] p0, p1, p2, p3;
    p3 = rk[127:96] ^ rk[95:64];
    p2 = rk[95:64]  ^ rk[63:32];
    p1 = rk[63:32]  ^ rk[31:0];
    p0 = rk[31:0] ^ sub_word(rot_word(p3)) ^ {24'h000000, rc};
    return {p3, p2, p1, p0};
  endfunction

endpackage

// File: rtl/aes_inv_round_comb.sv
// One combinational AES-128 inverse round plus the matching reverse key-expansion step.
module aes_inv_round_comb
  import aes_pkg::*;
(
  input  logic [127:0] st,
  input  logic [127:0] rk,
  input  logic [3:0]   rnd,
  output logic [127:0] next_st,
  output logic [127:0] next_rk
);

  logic [127:0] kp_s;
  logic [127:0] ark_s;

  // The final inverse round (rnd == 1) has no InvMixColumns.
  always_comb begin
    kp_s    = inv_key_step(rk, RCON[rnd]);
    ark_s   = inv_sub_bytes(inv_shift_rows(st)) ^ kp_s;
    next_rk = kp_s;
    if (rnd > 4'd1) next_st = inv_mix_columns(ark_s);
    else            next_st = ark_s;
  end

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 decryption core: one inverse round per clock, round keys derived backwards
// from the round-10 key, valid/ready handshakes on both sides.
module aes_inv_cipher_iter
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
  output logic [127:0] out_key,
  output logic         busy
);

  if (NR != 32'd10) begin : g_nr_check
    $error("aes_inv_cipher_iter: only NR = 10 (AES-128) is supported");
  end

  aes_state_e   state_r;
  aes_state_e   state_nxt_s;
  logic [127:0] st_r;
  logic [127:0] rk_r;
  logic [3:0]   rnd_r;
  logic         in_ready_r;
  logic         out_valid_r;
  logic         busy_r;
  logic         accept_s;
  logic         release_s;
  logic [127:0] next_st_s;
  logic [127:0] next_rk_s;

  aes_inv_round_comb u_round (
    .st      (st_r),
    .rk      (rk_r),
    .rnd     (rnd_r),
    .next_st (next_st_s),
    .next_rk (next_rk_s)
  );

  // Next-state decode and handshake qualification.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = in_valid && in_ready_r;
    release_s   = out_valid_r && out_ready;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_nxt_s = ST_RUN;
        else          state_nxt_s = ST_IDLE;
      end
      ST_RUN: begin
        if (rnd_r == 4'd1) state_nxt_s = ST_DONE;
        else               state_nxt_s = ST_RUN;
      end
      ST_DONE: begin
        if (release_s) state_nxt_s = ST_IDLE;
        else           state_nxt_s = ST_DONE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, datapath registers and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      st_r        <= 128'd0;
      rk_r        <= 128'd0;
      rnd_r       <= 4'd0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s == ST_IDLE);
      out_valid_r <= (state_nxt_s == ST_DONE);
      busy_r      <= (state_nxt_s != ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            st_r  <= in_block ^ in_key;
            rk_r  <= in_key;
            rnd_r <= 4'd10;
          end
        end
        ST_RUN: begin
          st_r  <= next_st_s;
          rk_r  <= next_rk_s;
          rnd_r <= rnd_r - 4'd1;
        end
        default: begin
          rnd_r <= rnd_r;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign out_block = st_r;
  assign out_key   = rk_r;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Directed bench for aes_inv_cipher_iter; expected values come from FIPS-197 constants and an
// independent forward-cipher model whose S-box is generated arithmetically.
module tb_aes_inv_cipher_iter;

  localparam logic [127:0] C1_CT  = 128'h5ac5b47080b7cdd830047b6ad8e0c469;
  localparam logic [127:0] C1_K10 = 128'hc5302b4d8ba707f3174a94e37f1d1113;
  localparam logic [127:0] C1_PT  = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] C1_KEY = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam int           NVEC   = 20;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_block;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_block;
  logic [127:0] out_key;
  logic         busy;

  int checks = 0;
  int errors = 0;

  logic [7:0]   sb [256];
  logic [7:0]   rc_tab [11];
  logic [127:0] rks [11];
  logic [127:0] v_ct [NVEC];
  logic [127:0] v_k10 [NVEC];
  logic [127:0] v_pt [NVEC];
  logic [127:0] v_key [NVEC];

  aes_inv_cipher_iter #(.NR(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_block  (in_block),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_block (out_block),
    .out_key   (out_key),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [7:0] mul2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    logic [15:0] t;
    t = {b, b};
    return t[15-k -: 8];
  endfunction

  // S-box from the generator-3 walk over GF(2^8) plus the affine map.
  task automatic build_tables();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    for (int i = 0; i < 255; i++) begin
      p = p ^ mul2(p);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sb[p] = x ^ 8'h63;
    end
    sb[0] = 8'h63;
    rc_tab[0] = 8'h00;
    rc_tab[1] = 8'h01;
    for (int i = 2; i < 11; i++) rc_tab[i] = mul2(rc_tab[i-1]);
  endtask

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[7:0], t[31:8]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {24'h000000, rc_tab[i/4]};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 0; k < 11; k++) rks[k] = {w[4*k+3], w[4*k+2], w[4*k+1], w[4*k]};
  endtask

  function automatic logic [127:0] enc(input logic [127:0] pt);
    logic [127:0] s, t;
    logic [7:0]   a [4];
    s = pt ^ rks[0];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int n = 0; n < 16; n++) s[8*n +: 8] = sb[s[8*n +: 8]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[8*(4*c+r) +: 8] = s[8*(4*((c+r)%4)+r) +: 8];
      s = t;
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          for (int r = 0; r < 4; r++) a[r] = s[8*(4*c+r) +: 8];
          for (int r = 0; r < 4; r++)
            t[8*(4*c+r) +: 8] = mul2(a[r]) ^ mul2(a[(r+1)%4]) ^ a[(r+1)%4] ^ a[(r+2)%4] ^ a[(r+3)%4];
        end
        s = t;
      end
      s = s ^ rks[rnd];
    end
    return s;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out_valid(input int limit, output int n);
    n = 0;
    while (!out_valid && n < limit) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    int sent;
    int got;
    int cyc;
    logic [127:0] pt_b, key_b, ct_b, k10_b;

    build_tables();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_block = 128'd0; in_key = 128'd0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk_bit("rst_in_ready", in_ready, 1'b1);
    chk_bit("rst_out_valid", out_valid, 1'b0);
    chk_bit("rst_busy", busy, 1'b0);
    chk("rst_out_block", out_block, 128'd0);
    chk("rst_out_key", out_key, 128'd0);

    // FIPS-197 C.1 with per-edge round-key tracking and exact latency
    expand(C1_KEY);
    in_valid = 1'b1; in_block = C1_CT; in_key = C1_K10; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; in_block = 128'hx; in_key = 128'hx;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk($sformatf("c1_rk_edge%0d", k), dut.rk_r, rks[10-k]);
      chk_bit($sformatf("c1_valid_edge%0d", k), out_valid, (k == 10));
    end
    chk("c1_block", out_block, C1_PT);
    chk("c1_key", out_key, C1_KEY);
    chk_bit("c1_done_busy", busy, 1'b1);
    chk_bit("c1_done_in_ready", in_ready, 1'b0);
    tick();
    chk_bit("c1_after_valid", out_valid, 1'b0);
    chk_bit("c1_after_in_ready", in_ready, 1'b1);
    chk_bit("c1_after_busy", busy, 1'b0);

    // Backpressure: 7 cycles of out_ready low while DONE
    in_block = 128'd0; in_key = 128'd0;
    out_ready = 1'b0;
    in_valid = 1'b1; in_block = C1_CT; in_key = C1_K10;
    tick();
    in_valid = 1'b0;
    wait_out_valid(30, n);
    chk_int("bp_latency", n, 10);
    for (int i = 0; i < 7; i++) begin
      chk_bit("bp_valid", out_valid, 1'b1);
      chk("bp_block", out_block, C1_PT);
      chk("bp_key", out_key, C1_KEY);
      chk_bit("bp_in_ready", in_ready, 1'b0);
      chk_bit("bp_busy", busy, 1'b1);
      tick();
    end
    chk_bit("bp_still_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    tick();
    chk_bit("bp_released", out_valid, 1'b0);
    chk_bit("bp_idle_ready", in_ready, 1'b1);

    // Busy rejection: second vector held on in_valid during RUN/DONE
    pt_b  = {$urandom(), $urandom(), $urandom(), $urandom()};
    key_b = {$urandom(), $urandom(), $urandom(), $urandom()};
    expand(key_b);
    ct_b  = enc(pt_b);
    k10_b = rks[10];
    out_ready = 1'b0;
    in_valid = 1'b1; in_block = C1_CT; in_key = C1_K10;
    tick();
    in_block = ct_b; in_key = k10_b;
    for (int i = 0; i < 12; i++) begin
      chk_bit("busy_in_ready", in_ready, 1'b0);
      tick();
    end
    chk_bit("busy_first_valid", out_valid, 1'b1);
    chk("busy_first_block", out_block, C1_PT);
    chk("busy_first_key", out_key, C1_KEY);
    out_ready = 1'b1;
    tick();
    chk_bit("busy_handshake_idle", in_ready, 1'b1);
    chk_bit("busy_handshake_valid", out_valid, 1'b0);
    tick();
    in_valid = 1'b0;
    chk_bit("busy_second_accepted", busy, 1'b1);
    wait_out_valid(30, n);
    chk_int("busy_second_latency", n, 10);
    chk("busy_second_block", out_block, pt_b);
    chk("busy_second_key", out_key, key_b);
    tick();

    // Reset sampled at E5 of RUN
    out_ready = 1'b1;
    in_valid = 1'b1; in_block = C1_CT; in_key = C1_K10;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_bit("mid_rst_in_ready", in_ready, 1'b1);
    chk_bit("mid_rst_valid", out_valid, 1'b0);
    chk_bit("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_block", out_block, 128'd0);
    chk("mid_rst_key", out_key, 128'd0);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk_bit("mid_rst_no_output", out_valid, 1'b0);
    end
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out_valid(30, n);
    chk_int("mid_rst_rerun_latency", n, 10);
    chk("mid_rst_rerun_block", out_block, C1_PT);
    chk("mid_rst_rerun_key", out_key, C1_KEY);
    tick();

    // Back-to-back random vectors with random backpressure
    for (int i = 0; i < NVEC; i++) begin
      v_pt[i]  = {$urandom(), $urandom(), $urandom(), $urandom()};
      v_key[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
      expand(v_key[i]);
      v_ct[i]  = enc(v_pt[i]);
      v_k10[i] = rks[10];
    end
    sent = 0;
    got  = 0;
    cyc  = 0;
    while (got < NVEC && cyc < 4000) begin
      out_ready = ($urandom_range(0, 2) != 0);
      in_valid  = (sent < NVEC);
      if (sent < NVEC) begin
        in_block = v_ct[sent];
        in_key   = v_k10[sent];
      end else begin
        in_block = 128'd0;
        in_key   = 128'd0;
      end
      if (out_valid && out_ready) begin
        chk_bit("b2b_in_flight", (got < sent), 1'b1);
        if (got < sent) begin
          chk($sformatf("b2b_block%0d", got), out_block, v_pt[got]);
          chk($sformatf("b2b_key%0d", got), out_key, v_key[got]);
        end
        got++;
      end
      if (in_valid && in_ready) sent++;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    chk_int("b2b_received", got, NVEC);
    chk_int("b2b_sent", sent, NVEC);
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk_bit("b2b_no_duplicate", out_valid, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_inv_cipher_iter.md
Name: aes_inv_cipher_iter

Overview:
Iterative AES-128 inverse cipher (decryption) core. It is the decrypt-direction counterpart of the forward SubBytes datapath.
- Takes one ciphertext block plus the final (round-10) round key over a valid/ready handshake.
- Executes one inverse round per clock.
- Derives round keys on the fly by reverse key expansion.
- Returns the plaintext and the recovered cipher key over a second valid/ready handshake.

Parameters:
NR, 10, number of rounds; only 10 (AES-128) is legal. Elaboration must fail on any other value.

Ports:
clk  in  1  clock; all logic on the rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  ciphertext and key presented
in_ready  out  1  core can accept; high only in IDLE
in_block  in  128  ciphertext; byte n = bits [8n+7:8n], column-major (row n%4, column n/4)
in_key  in  128  round-10 round key, same byte order
out_valid  out  1  result available
out_ready  in  1  downstream accepts result
out_block  out  128  plaintext, same byte order
out_key  out  128  recovered round-0 key (= cipher key)
busy  out  1  high in RUN and DONE

Behaviour:
- Reset (rst sampled high at an edge): state=IDLE, round counter=0, in_ready=1, out_valid=0, busy=0, out_block=0, out_key=0.
  - Reset mid-RUN or mid-DONE discards the operation. No output handshake occurs.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at edge E0: st <= in_block ^ in_key; rk <= in_key; rnd <= 10; go to RUN.
  - in_block and in_key are sampled only at E0.
- RUN (edges E1..E10), one round per edge:
  - kp = inv_key_step(rk, rcon[rnd]), with rk words w0..w3 (w0 = bytes 0-3):
    - p3 = w3^w2; p2 = w2^w1; p1 = w1^w0.
    - p0 = w0 ^ SubWord(RotWord(p3)) ^ {rcon,00,00,00}, with rcon in byte 0 of the word.
  - rnd>1: st <= InvMixColumns(InvSubBytes(InvShiftRows(st)) ^ kp).
  - rnd==1: st <= InvSubBytes(InvShiftRows(st)) ^ kp, with no InvMixColumns; go to DONE.
  - Every RUN edge: rk <= kp; rnd <= rnd-1.
  - in_ready=0 throughout RUN; in_valid is ignored.
- DONE:
  - out_valid=1; out_block=st; out_key=rk. Values are held stable until out_valid&&out_ready.
  - On the handshake, return to IDLE. in_ready rises the next cycle, so there is no same-cycle accept.
  - If out_ready is high on entry, DONE lasts exactly one cycle.
- Latency: out_valid is first high in the cycle after E10, i.e. 10 edges after the accepting edge.
  - Throughput with out_ready tied high: one block per 12 cycles.
- Outputs come from registers only. There is no combinational path from in_* to out_*.
- InvShiftRows: row r rotates right by r. out byte (r,c) = in byte (r, (c-r) mod 4).
- InvMixColumns: matrix {0e,0b,0d,09} circulant over GF(2^8), reduction polynomial 0x11b.
- rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- X/unknown on in_block/in_key outside the handshake must not propagate into state.

Decomposition:
- Package aes_pkg holds:
  - s_box and inv_s_box constant arrays (256x8).
  - rcon array.
  - Functions xtime, gmul, inv_shift_rows, inv_mix_columns, sub_word, rot_word.
  - The byte-index convention constant.
- One natural sub-module: aes_inv_round_comb. It is purely combinational, with inputs st, rk, rnd and outputs next_st, next_rk.
  - The top keeps the FSM, registers and handshake only.

Test Plan:
- FIPS-197 C.1 vector:
  - Stimulus: in_block=0x5ac5b47080b7cdd830047b6ad8e0c469, in_key=0xc5302b4d8ba707f3174a94e37f1d1113, out_ready=1.
  - Response: out_valid exactly 10 edges after accept; out_block=0xffeeddccbbaa99887766554433221100; out_key=0x0f0e0d0c0b0a09080706050403020100.
- Backpressure:
  - Stimulus: same vector with out_ready low for 7 cycles after out_valid.
  - Response: out_block/out_key stable; in_ready=0; busy=1; one handshake completes when out_ready rises.
- Busy rejection:
  - Stimulus: in_valid held high with a second vector during RUN.
  - Response: in_ready=0; first result unaffected; second vector accepted only in the cycle after the output handshake.
- Reset mid-operation:
  - Stimulus: assert rst at E5 of RUN.
  - Response: next cycle state IDLE, out_valid=0, in_ready=1, outputs 0. A fresh C.1 run then produces the correct plaintext.
- Back-to-back:
  - Stimulus: 20 random blocks/keys against a reference-model decrypt, in_valid always high, out_ready randomly toggled.
  - Response: all results match, in order, with no drops or duplicates.
- Key-step corner:
  - Stimulus: in_key from a known expansion with rcon=0x1b/0x36 rounds.
  - Response: rk at each RUN edge matches the model's round keys 9..0.
